// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, rotate/sigma helpers and the schedule expander state type.
package sha256_pkg;

  localparam int WORDS_IN_CHUNK = 16;
  localparam int SCHEDULE_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    OUTPUT = 2'd2
  } MsaExpanderState;

  function automatic logic [31:0] rightRotate32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0_32(input logic [31:0] x);
    return rightRotate32(x, 7) ^ rightRotate32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1_32(input logic [31:0] x);
    return rightRotate32(x, 17) ^ rightRotate32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/msa_schedule_expander_if.sv
// Chunk-in / schedule-out handshake bundle between the chunk source, the expander and the compressor.
// The slave modport is the expander's view; the master modport drives chunks and consumes schedules.
interface msa_schedule_expander_if;

  logic              chunk_vld;
  logic              chunk_rdy;
  logic [63:0][7:0]  chunk;
  logic              w_vld;
  logic              w_rdy;
  logic [63:0][31:0] w;
  logic              busy;

  modport master (
    output chunk_vld, chunk, w_rdy,
    input  chunk_rdy, w_vld, w, busy
  );

  modport slave (
    input  chunk_vld, chunk, w_rdy,
    output chunk_rdy, w_vld, w, busy
  );

endinterface

// File: rtl/msa_sched_word.sv
// One SHA-256 schedule word: sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
// Purely combinational; no handshake of its own.
module msa_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w_m2,
  input  logic [31:0] w_m7,
  input  logic [31:0] w_m15,
  input  logic [31:0] w_m16,
  output logic [31:0] w_new
);

  assign w_new = sigma1_32(w_m2) + w_m7 + sigma0_32(w_m15) + w_m16;

endmodule

// File: rtl/msa_schedule_expander.sv
// Expands a 512-bit chunk into W[0..63], WORDS_PER_CYCLE words per clock; w_vld 1+48/WPC cycles after accept.
// Schedule is held stable in OUTPUT until w_rdy; chunk_rdy only in IDLE, so no chunk is taken while busy.
module msa_schedule_expander
  import sha256_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  msa_schedule_expander_if.slave io
);

  if (WORDS_PER_CYCLE < 1 || WORDS_PER_CYCLE > 4 || (48 % WORDS_PER_CYCLE) != 0) begin : g_bad_wpc
    $error("msa_schedule_expander: WORDS_PER_CYCLE must be 1, 2, 3 or 4 and divide 48");
  end

  MsaExpanderState                     r_state;
  MsaExpanderState                     w_state_nxt;
  logic [6:0]                          r_idx;
  logic [SCHEDULE_WORDS-1:0][31:0]     r_w;

  logic                                w_accept;
  logic                                w_last;
  logic [5:0]                          w_t     [WORDS_PER_CYCLE];
  logic [31:0]                         w_m2    [WORDS_PER_CYCLE];
  logic [31:0]                         w_new   [WORDS_PER_CYCLE];

  assign io.chunk_rdy = rst_n & (r_state == IDLE);
  assign io.w_vld     = (r_state == OUTPUT);
  assign io.busy      = (r_state == EXPAND) | (r_state == OUTPUT);
  assign io.w         = r_w;

  assign w_accept = io.chunk_vld & io.chunk_rdy;
  assign w_last   = (r_idx + 7'(WORDS_PER_CYCLE)) == 7'(SCHEDULE_WORDS);

  // Later words in the same cycle take W[t-2] from the chain, not from r_w, which is not yet written.
  for (genvar k = 0; k < WORDS_PER_CYCLE; k++) begin : g_word
    assign w_t[k] = r_idx[5:0] + 6'(k);

    if (k >= 2) begin : g_chain
      assign w_m2[k] = w_new[k-2];
    end else begin : g_reg
      assign w_m2[k] = r_w[w_t[k] - 6'd2];
    end

    msa_sched_word u_word (
      .w_m2  (w_m2[k]),
      .w_m7  (r_w[w_t[k] - 6'd7]),
      .w_m15 (r_w[w_t[k] - 6'd15]),
      .w_m16 (r_w[w_t[k] - 6'd16]),
      .w_new (w_new[k])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXPAND;
      EXPAND:  if (w_last)   w_state_nxt = OUTPUT;
      OUTPUT:  if (io.w_rdy) w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_w     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            for (int i = 0; i < WORDS_IN_CHUNK; i++) begin
              r_w[i] <= {io.chunk[4*i], io.chunk[4*i+1], io.chunk[4*i+2], io.chunk[4*i+3]};
            end
            r_idx <= 7'(WORDS_IN_CHUNK);
          end
        end
        EXPAND: begin
          for (int k = 0; k < WORDS_PER_CYCLE; k++) begin
            r_w[w_t[k]] <= w_new[k];
          end
          r_idx <= r_idx + 7'(WORDS_PER_CYCLE);
        end
        OUTPUT: begin
          if (io.w_rdy) r_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msa_schedule_expander.sv
// Scoreboard bench for msa_schedule_expander at WORDS_PER_CYCLE = 1, 2 and 4.
// Drivers push expected schedules; a negedge monitor pops and compares on every w_vld & w_rdy transfer.
module tb_msa_schedule_expander;

  typedef logic [63:0][7:0]  chunk_t;
  typedef logic [63:0][31:0] sched_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  logic   c_vld   [3];
  chunk_t c_dat   [3];
  logic   w_rdy_a [3];
  logic   c_rdy   [3];
  logic   wv      [3];
  logic   bsy     [3];
  sched_t w_a     [3];
  sched_t last_w  [3];
  sched_t exp_q   [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance g runs WORDS_PER_CYCLE = 1 << g.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    msa_schedule_expander_if ifc ();
    assign ifc.chunk_vld = c_vld[g];
    assign ifc.chunk     = c_dat[g];
    assign ifc.w_rdy     = w_rdy_a[g];
    assign c_rdy[g]      = ifc.chunk_rdy;
    assign wv[g]         = ifc.w_vld;
    assign bsy[g]        = ifc.busy;
    assign w_a[g]        = ifc.w;

    msa_schedule_expander #(.WORDS_PER_CYCLE(1 << g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (ifc.slave)
    );
  end

  function automatic sched_t model(input chunk_t c);
    logic [31:0] m [64];
    logic [31:0] s0, s1;
    sched_t      r;
    for (int i = 0; i < 16; i++) m[i] = {c[4*i], c[4*i+1], c[4*i+2], c[4*i+3]};
    for (int t = 16; t < 64; t++) begin
      s0 = {m[t-15][6:0], m[t-15][31:7]} ^ {m[t-15][17:0], m[t-15][31:18]} ^ (m[t-15] >> 3);
      s1 = {m[t-2][16:0], m[t-2][31:17]} ^ {m[t-2][18:0], m[t-2][31:19]} ^ (m[t-2] >> 10);
      m[t] = s1 + m[t-7] + s0 + m[t-16];
    end
    for (int i = 0; i < 64; i++) r[i] = m[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_w(input string name, input sched_t act, input sched_t exp);
    int bad;
    bad = -1;
    for (int i = 63; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: W[%0d] got %08h, expected %08h (cycle %0d)", name, bad, act[bad], exp[bad], cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst_n && wv[d] && w_rdy_a[d]) begin
        last_w[d] = w_a[d];
        if (exp_q[d].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_schedule dut%0d: got a transfer, expected none (cycle %0d)", d, cyc);
        end else begin
          chk_w($sformatf("schedule_dut%0d", d), w_a[d], exp_q[d].pop_front());
        end
      end
    end
  end

  // Runs in the phase just after a rising edge; returns one cycle after the handshake.
  task automatic send(input int d, input chunk_t c, output int hs);
    int n;
    n = 0;
    hs = -1;
    c_dat[d] = c;
    c_vld[d] = 1'b1;
    while (!c_rdy[d] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!c_rdy[d]) begin
      chk($sformatf("accept_timeout_dut%0d", d), 1, 0);
      c_vld[d] = 1'b0;
    end else begin
      hs = cyc;
      exp_q[d].push_back(model(c));
      @(posedge clk); #1;
      c_vld[d] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("drain_dut%0d", d), exp_q[d].size(), 0);
  endtask

  task automatic b2b(input int d);
    chunk_t c;
    int     hs, hs_prev;
    w_rdy_a[d] = 1'b1;
    hs_prev = -1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) c[i] = 8'($urandom_range(0, 255));
      send(d, c, hs);
      if (k > 0) chk($sformatf("b2b_period_dut%0d", d), 64'(hs - hs_prev), 64'(48 / (1 << d) + 2));
      hs_prev = hs;
    end
    wait_drain(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chunk_t abc, zero_c, ff_c, hold_c;
    sched_t hold_exp;
    int     hs, n, seen;

    abc = '0;
    abc[0] = 8'h61; abc[1] = 8'h62; abc[2] = 8'h63; abc[3] = 8'h80; abc[63] = 8'h18;
    zero_c = '0;
    ff_c = '1;
    for (int i = 0; i < 64; i++) hold_c[i] = 8'(i * 3 + 1);

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      c_vld[d] = 1'b0; c_dat[d] = '0; w_rdy_a[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_chunk_rdy_dut%0d", d), c_rdy[d], 0);
      chk($sformatf("reset_w_vld_dut%0d", d), wv[d], 0);
      chk($sformatf("reset_busy_dut%0d", d), bsy[d], 0);
      chk_w($sformatf("reset_w_dut%0d", d), w_a[d], '0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_reset_chunk_rdy", c_rdy[0], 1);
    @(posedge clk); #1;

    // "abc" chunk: latency and hand-derived words
    w_rdy_a[0] = 1'b1;
    send(0, abc, hs);
    n = 0;
    while (!wv[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abc_latency", 64'(cyc - hs), 49);
    wait_drain(0);
    chk("abc_W0", last_w[0][0], 32'h61626380);
    chk("abc_W15", last_w[0][15], 32'h00000018);
    chk("abc_W16", last_w[0][16], 32'h61626380);
    chk("abc_W17", last_w[0][17], 32'h000F0000);

    send(0, zero_c, hs);
    wait_drain(0);
    chk_w("zero_all_words", last_w[0], '0);

    send(0, ff_c, hs);
    wait_drain(0);
    chk("ff_W0", last_w[0][0], 32'hFFFFFFFF);
    chk("ff_W16", last_w[0][16], 32'h203FFFFC);

    // Backpressure hold with an ignored chunk pulse in the middle
    w_rdy_a[0] = 1'b0;
    hold_exp = model(hold_c);
    send(0, hold_c, hs);
    n = 0;
    while (!wv[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      chk("hold_w_vld", wv[0], 1);
      chk("hold_chunk_rdy", c_rdy[0], 0);
      chk_w("hold_w_stable", w_a[0], hold_exp);
      if (k == 5) begin
        c_dat[0] = ~hold_c;
        c_vld[0] = 1'b1;
      end
      if (k == 6) c_vld[0] = 1'b0;
      @(posedge clk); #1;
    end
    w_rdy_a[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_chunk_rdy", c_rdy[0], 1);
    chk("release_w_vld", wv[0], 0);
    chk("hold_drained", exp_q[0].size(), 0);
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (wv[0] || bsy[0]) seen++;
    end
    chk("ignored_chunk_no_activity", seen, 0);

    // Reset in EXPAND cycle 20, then a clean "abc"
    send(0, hold_c, hs);
    repeat (19) @(posedge clk);
    #1;
    chk("pre_reset_busy", bsy[0], 1);
    rst_n = 1'b0;
    exp_q[0].delete();
    #1;
    chk("midreset_w_vld", wv[0], 0);
    chk("midreset_busy", bsy[0], 0);
    chk("midreset_chunk_rdy", c_rdy[0], 0);
    chk_w("midreset_w_cleared", w_a[0], '0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wv[0]) seen++;
    end
    chk("midreset_w_vld_hold", seen, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, abc, hs);
    wait_drain(0);
    chk("post_reset_abc_W17", last_w[0][17], 32'h000F0000);

    fork
      b2b(0);
      b2b(1);
      b2b(2);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
